// File: rtl/led_fade_pwm.sv
// LED afterglow stage: latches the chaser pattern, decays per-LED brightness and drives a 15-slot PWM.
// Optional macro LED_FADE_GAMMA_EN maps brightness through a perceptual gamma table before the PWM compare.
module led_fade_pwm #(
    parameter int unsigned PWM_DIV   = 64,
    parameter int unsigned DECAY_DIV = 262144
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] PATTERN,
    input  logic        STEP,
    output logic [15:0] LED,
    output logic        PWM_SYNC
);

    localparam int unsigned PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned DW = $clog2(DECAY_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(PWM_DIV - 1);
    localparam logic [DW-1:0] DEC_LAST = DW'(DECAY_DIV - 1);

    logic [PW-1:0]      presc_q, presc_d;
    logic [3:0]         pwm_cnt_q, pwm_cnt_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;
    logic [15:0]        cur_pat_q, cur_pat_d;
    logic [15:0][3:0]   bri_q, bri_d;
    logic [15:0][3:0]   bri_eff;
    logic [15:0]        led_q, led_d;
    logic               sync_q, sync_d;
    logic               slot_wrap, decay_tick;
    logic [15:0]        eff_pat;

`ifdef LED_FADE_GAMMA_EN
    function automatic logic [3:0] gamma(input logic [3:0] b);
        case (b)
            4'd0:  gamma = 4'd0;
            4'd1:  gamma = 4'd1;
            4'd2:  gamma = 4'd1;
            4'd3:  gamma = 4'd1;
            4'd4:  gamma = 4'd2;
            4'd5:  gamma = 4'd2;
            4'd6:  gamma = 4'd3;
            4'd7:  gamma = 4'd4;
            4'd8:  gamma = 4'd5;
            4'd9:  gamma = 4'd6;
            4'd10: gamma = 4'd7;
            4'd11: gamma = 4'd8;
            4'd12: gamma = 4'd10;
            4'd13: gamma = 4'd11;
            4'd14: gamma = 4'd13;
            default: gamma = 4'd15;
        endcase
    endfunction

    always_comb begin
        bri_eff = '0;
        for (int unsigned i = 0; i < 16; i++) bri_eff[i] = gamma(bri_q[i]);
    end
`else
    always_comb bri_eff = bri_q;
`endif

    always_comb begin
        slot_wrap = (presc_q == PRE_LAST);
        presc_d   = slot_wrap ? '0 : presc_q + 1'b1;
        pwm_cnt_d = pwm_cnt_q;
        sync_d    = 1'b0;
        if (slot_wrap) begin
            if (pwm_cnt_q == 4'd14) begin
                pwm_cnt_d = '0;
                sync_d    = 1'b1;
            end else begin
                pwm_cnt_d = pwm_cnt_q + 4'd1;
            end
        end

        decay_tick = (dcnt_q == DEC_LAST);
        dcnt_d     = decay_tick ? '0 : dcnt_q + 1'b1;

        // A pattern bit presented on STEP takes effect this cycle, so newly lit bits skip the decay.
        eff_pat   = STEP ? PATTERN : cur_pat_q;
        cur_pat_d = eff_pat;
        bri_d     = bri_q;
        led_d     = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (eff_pat[i])
                bri_d[i] = 4'hF;
            else if (decay_tick && (bri_q[i] != 4'h0))
                bri_d[i] = bri_q[i] - 4'd1;
            led_d[i] = (pwm_cnt_q < bri_eff[i]);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            dcnt_q    <= '0;
            cur_pat_q <= '0;
            bri_q     <= '0;
            led_q     <= '0;
            sync_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            dcnt_q    <= dcnt_d;
            cur_pat_q <= cur_pat_d;
            bri_q     <= bri_d;
            led_q     <= led_d;
            sync_q    <= sync_d;
        end
    end

    assign LED      = led_q;
    assign PWM_SYNC = sync_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Scoreboard bench for led_fade_pwm: a cycle-count reference model predicts LED/PWM_SYNC for two configurations.
module tb_led_fade_pwm;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        STEP = 1'b0;
    logic [15:0] PATTERN = '0;
    logic [15:0] led0, led4;
    logic        sync0, sync4;

    always #5 CLK = ~CLK;

    led_fade_pwm #(.PWM_DIV(1), .DECAY_DIV(32)) dut (
        .CLK(CLK), .RESET(RESET), .PATTERN(PATTERN), .STEP(STEP),
        .LED(led0), .PWM_SYNC(sync0)
    );

    led_fade_pwm #(.PWM_DIV(4), .DECAY_DIV(600)) dut4 (
        .CLK(CLK), .RESET(RESET), .PATTERN(PATTERN), .STEP(STEP),
        .LED(led4), .PWM_SYNC(sync4)
    );

    typedef struct packed {
        logic [15:0] led;
        logic        sync;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned c = 0;
    int unsigned pdiv[2] = '{1, 4};
    int unsigned ddiv[2] = '{32, 600};
    int unsigned bri_m[2][16];
    logic [15:0] cur_m[2];

    function automatic int unsigned eff(input int unsigned b);
`ifdef LED_FADE_GAMMA_EN
        int unsigned g[16] = '{0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 7, 8, 10, 11, 13, 15};
        return g[b];
`else
        return b;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        c = 0;
        for (int k = 0; k < 2; k++) begin
            cur_m[k] = '0;
            for (int i = 0; i < 16; i++) bri_m[k][i] = 0;
        end
    endtask

    // Predicts the outputs produced by the coming clock edge (cycle index c since reset release).
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            exp_t        e;
            bit          tick;
            int unsigned slot;
            tick   = (c % ddiv[k]) == ddiv[k] - 1;
            slot   = (c / pdiv[k]) % 15;
            e.sync = ((c + 1) % (15 * pdiv[k])) == 0;
            for (int i = 0; i < 16; i++) e.led[i] = slot < eff(bri_m[k][i]);
            for (int i = 0; i < 16; i++) begin
                if (STEP ? PATTERN[i] : cur_m[k][i]) bri_m[k][i] = 15;
                else if (tick && bri_m[k][i] != 0) bri_m[k][i] = bri_m[k][i] - 1;
            end
            if (STEP) cur_m[k] = PATTERN;
            if (k == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        c++;
    endtask

    task automatic cycle(input logic step, input logic [15:0] pat);
        STEP = step;
        PATTERN = pat;
        model_step();
        @(negedge CLK);
    endtask

    always @(posedge CLK) begin : monitor
        exp_t e;
        #1;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            check("led_div1", {16'h0, led0}, {16'h0, e.led});
            check("sync_div1", {31'h0, sync0}, {31'h0, e.sync});
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check("led_div4", {16'h0, led4}, {16'h0, e.led});
            check("sync_div4", {31'h0, sync4}, {31'h0, e.sync});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        int          ones, ones1;
        bit          found;

        repeat (2) @(negedge CLK);
        check("por_led", {16'h0, led0}, 32'h0);
        check("por_sync", {31'h0, sync0}, 32'h0);
        RESET = 1'b1;
        model_reset();
        repeat (40) cycle(1'b0, 16'h0);

        // Full on: bits 13..0 lit in every slot, 15..14 dark
        cycle(1'b1, 16'h3FFF);
        repeat (2) cycle(1'b0, 16'h0);
        for (int i = 0; i < 15; i++) begin
            check("full_on", {16'h0, led0}, 32'h3FFF);
            cycle(1'b0, 16'h0);
        end

        // Asynchronous reset mid-run clears outputs without a clock edge
        STEP = 1'b0;
        RESET = 1'b0;
        #1;
        check("async_rst_led0", {16'h0, led0}, 32'h0);
        check("async_rst_sync0", {31'h0, sync0}, 32'h0);
        check("async_rst_led4", {16'h0, led4}, 32'h0);
        check("async_rst_sync4", {31'h0, sync4}, 32'h0);
        model_reset();
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        n = 0;
        found = 0;
        while (!found && n < 30) begin
            cycle(1'b0, 16'h0);
            n++;
            if (sync0) found = 1;
        end
        check("first_sync_delay", n, 15);
        repeat (40) cycle(1'b0, 16'h0);

        // Fade tail on LED0
        cycle(1'b1, 16'h0001);
        cycle(1'b1, 16'h0000);
        repeat (16 * 32 + 15) cycle(1'b0, 16'h0);
        ones = 0;
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 16'h0);
            ones += int'(led0[0]);
        end
        check("tail_end_dark", ones, 0);

        // STEP coinciding with a decay tick
        cycle(1'b1, 16'h0001);
        while ((c % 32) != 31) cycle(1'b0, 16'h0);
        cycle(1'b1, 16'h0002);
        cycle(1'b0, 16'h0);
        ones = 0;
        ones1 = 0;
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 16'h0);
            ones += int'(led0[0]);
            ones1 += int'(led0[1]);
        end
        check("simul_led0_duty", ones, eff(14));
        check("simul_led1_duty", ones1, 15);

        // Re-light LED2 at BRI=6 on a decay-tick cycle
        cycle(1'b1, 16'h0004);
        cycle(1'b1, 16'h0000);
        n = 0;
        while (!(bri_m[0][2] == 6 && (c % 32) == 31) && n < 1000) begin
            cycle(1'b0, 16'h0);
            n++;
        end
        cycle(1'b1, 16'h0004);
        cycle(1'b0, 16'h0);
        ones = 0;
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 16'h0);
            ones += int'(led0[2]);
        end
        check("relight_duty", ones, 15);

        // Random patterns and STEP timing
        repeat (300) cycle($urandom_range(0, 3) == 0, 16'($urandom & $urandom));

        // PWM_DIV=4 instance: hold BRI=5 and measure one 60-cycle frame
        cycle(1'b1, 16'h0001);
        cycle(1'b1, 16'h0000);
        n = 0;
        while (bri_m[1][0] != 5 && n < 20000) begin
            cycle(1'b0, 16'h0);
            n++;
        end
        cycle(1'b0, 16'h0);
        found = 0;
        n = 0;
        while (!found && n < 200) begin
            cycle(1'b0, 16'h0);
            n++;
            if (sync4) found = 1;
        end
        check("pwm4_sync_seen", {31'h0, found}, 32'h1);
        ones = int'(led4[0]);
        for (int i = 0; i < 59; i++) begin
            cycle(1'b0, 16'h0);
            ones += int'(led4[0]);
        end
        check("pwm4_duty", ones, 4 * eff(5));

        repeat (3) cycle(1'b0, 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
